// File: rtl/control_unit.sv
// control_unit: Moore sequencing FSM driving data_path through fetch, decode and execute.
// Optional CONTROL_UNIT_MEM_WAIT_EN adds FETCH_WAIT/LOAD_WAIT for a registered-read RAM.
package control_unit_pkg;
  typedef enum logic [3:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT
  } decoded_instruction_type;
endpackage

module control_unit
  import control_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic [CNT_W-1:0]        instr_count
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_LOAD, S_STORE, S_ALU, S_MOVE, S_BR, S_HALT,
    S_FETCH_WAIT, S_LOAD_WAIT
  } state_t;

  typedef struct packed {
    logic       branch;
    logic       pc_enable;
    logic       ir_enable;
    logic       addr_sel;
    logic       c_sel;
    logic [1:0] operation;
    logic       write_reg_enable;
    logic       flags_reg_enable;
    logic       ram_write_enable;
    logic       halt;
  } ctrl_t;

`ifdef CONTROL_UNIT_MEM_WAIT_EN
  localparam state_t RETURN_STATE = S_FETCH_WAIT;
  localparam state_t LOAD_ENTRY   = S_LOAD_WAIT;
`else
  localparam state_t RETURN_STATE = S_FETCH;
  localparam state_t LOAD_ENTRY   = S_LOAD;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state, state_next;
  ctrl_t            ctrl_q, ctrl_next;
  logic             taken;
  logic [CNT_W-1:0] count_q;

  function automatic logic [1:0] alu_op(decoded_instruction_type instr);
    case (instr)
      I_SUB:   return 2'b01;
      I_AND:   return 2'b10;
      I_OR:    return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Controls are a pure function of the state being entered, so they can be registered alongside it.
  function automatic ctrl_t ctrl_of(state_t s, decoded_instruction_type instr);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:                 begin c.ir_enable = 1'b1; c.pc_enable = 1'b1; end
      S_DECODE, S_LOAD_WAIT:   c.addr_sel = 1'b1;
      S_LOAD:                  begin c.addr_sel = 1'b1; c.c_sel = 1'b1; c.write_reg_enable = 1'b1; end
      S_STORE:                 begin c.addr_sel = 1'b1; c.ram_write_enable = 1'b1; end
      S_ALU: begin
        c.operation        = alu_op(instr);
        c.write_reg_enable = 1'b1;
        c.flags_reg_enable = 1'b1;
      end
      S_MOVE:                  begin c.operation = 2'b11; c.write_reg_enable = 1'b1; end
      S_BR:                    begin c.pc_enable = 1'b1; c.branch = 1'b1; c.addr_sel = 1'b1; end
      S_HALT:                  c.halt = 1'b1;
      default:                 c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    taken = 1'b0;
    case (decoded_instruction)
      I_BZERO:  taken = zero_op;
      I_BNZERO: taken = ~zero_op;
      I_BNEG:   taken = neg_op;
      I_BNNEG:  taken = ~neg_op;
      I_BOV:    taken = unsigned_overflow | signed_overflow;
      I_BNOV:   taken = ~(unsigned_overflow | signed_overflow);
      default:  taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next = RETURN_STATE;
    case (state)
      S_FETCH_WAIT: state_next = S_FETCH;
      S_FETCH:      state_next = S_DECODE;
      S_DECODE: begin
        case (decoded_instruction)
          I_LOAD:                      state_next = LOAD_ENTRY;
          I_STORE:                     state_next = S_STORE;
          I_MOVE:                      state_next = S_MOVE;
          I_HALT:                      state_next = S_HALT;
          I_ADD, I_SUB, I_AND, I_OR:   state_next = S_ALU;
          I_BRANCH:                    state_next = S_BR;
          I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV:
            state_next = taken ? S_BR : RETURN_STATE;
          default:                     state_next = RETURN_STATE;
        endcase
      end
      S_LOAD_WAIT:  state_next = S_LOAD;
      S_HALT:       state_next = S_HALT;
      default:      state_next = RETURN_STATE;
    endcase
    ctrl_next = ctrl_of(state_next, decoded_instruction);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RETURN_STATE;
      ctrl_q  <= ctrl_of(RETURN_STATE, I_NOP);
      count_q <= '0;
    end else begin
      state  <= state_next;
      ctrl_q <= ctrl_next;
      if (state_next == RETURN_STATE && count_q != CNT_MAX)
        count_q <= count_q + 1'b1;
    end
  end

  // Reset masks the registered controls so FETCH enables stay low while rst is held.
  assign branch           = ctrl_q.branch & ~rst;
  assign pc_enable        = ctrl_q.pc_enable & ~rst;
  assign ir_enable        = ctrl_q.ir_enable & ~rst;
  assign addr_sel         = ctrl_q.addr_sel & ~rst;
  assign c_sel            = ctrl_q.c_sel & ~rst;
  assign operation        = ctrl_q.operation & {2{~rst}};
  assign write_reg_enable = ctrl_q.write_reg_enable & ~rst;
  assign flags_reg_enable = ctrl_q.flags_reg_enable & ~rst;
  assign ram_write_enable = ctrl_q.ram_write_enable & ~rst;
  assign halt             = ctrl_q.halt & ~rst;
  assign instr_count      = count_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench; the driver queues per-instruction control traces, the monitor compares them.
module tb_control_unit;
  import control_unit_pkg::*;

  localparam int CNT_W   = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // {branch, pc_en, ir_en, addr_sel, c_sel, op[1:0], wre, fre, ram_we, halt}
  localparam logic [10:0] W_FETCH  = 11'b0_1_1_0_0_00_0_0_0_0;
  localparam logic [10:0] W_DECODE = 11'b0_0_0_1_0_00_0_0_0_0;
  localparam logic [10:0] W_LOAD   = 11'b0_0_0_1_1_00_1_0_0_0;
  localparam logic [10:0] W_STORE  = 11'b0_0_0_1_0_00_0_0_1_0;
  localparam logic [10:0] W_ADD    = 11'b0_0_0_0_0_00_1_1_0_0;
  localparam logic [10:0] W_SUB    = 11'b0_0_0_0_0_01_1_1_0_0;
  localparam logic [10:0] W_AND    = 11'b0_0_0_0_0_10_1_1_0_0;
  localparam logic [10:0] W_OR     = 11'b0_0_0_0_0_11_1_1_0_0;
  localparam logic [10:0] W_MOVE   = 11'b0_0_0_0_0_11_1_0_0_0;
  localparam logic [10:0] W_BR     = 11'b1_1_0_1_0_00_0_0_0_0;
  localparam logic [10:0] W_HALT   = 11'b0_0_0_0_0_00_0_0_0_1;

  typedef struct {
    string             name;
    int                len;
    logic [5:0][10:0]  words;
    logic [CNT_W-1:0]  count;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  decoded_instruction_type decoded_instruction;
  logic zero_op, neg_op, unsigned_overflow, signed_overflow;
  logic branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic [1:0] operation;
  logic write_reg_enable, flags_reg_enable, ram_write_enable, halt;
  logic [CNT_W-1:0] instr_count;

  exp_t             sb[$];
  logic [10:0]      trace[$];
  bit               halted = 1'b0;
  logic [CNT_W-1:0] halt_count = '0;
  int               vectors = 0;
  int               miscompares = 0;
  int               exp_retired = 0;

  always #5 clk = ~clk;

  control_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .decoded_instruction(decoded_instruction),
    .zero_op(zero_op), .neg_op(neg_op),
    .unsigned_overflow(unsigned_overflow), .signed_overflow(signed_overflow),
    .branch(branch), .pc_enable(pc_enable), .ir_enable(ir_enable),
    .addr_sel(addr_sel), .c_sel(c_sel), .operation(operation),
    .write_reg_enable(write_reg_enable), .flags_reg_enable(flags_reg_enable),
    .ram_write_enable(ram_write_enable), .halt(halt), .instr_count(instr_count)
  );

  function automatic logic [10:0] ctrl_word();
    return {branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
            write_reg_enable, flags_reg_enable, ram_write_enable, halt};
  endfunction

  task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Issue one instruction during its FETCH cycle and queue the control trace it should produce.
  task automatic apply_stimulus(input string name, input decoded_instruction_type instr,
                                input logic [3:0] flags, input int len, input logic [10:0] last_word,
                                input bit retires, input bit push);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk);
    while (!ir_enable) begin
      guard++;
      if (guard > 20) begin
        $display("[TB] FAIL fetch_timeout: no ir_enable within 20 cycles before %s", name);
        $fatal(1, "[TB] stopping: controller never returned to fetch");
      end
      @(negedge clk);
    end
    decoded_instruction = instr;
    {zero_op, neg_op, unsigned_overflow, signed_overflow} = flags;
    if (push) begin
      if (retires) exp_retired++;
      e.name     = name;
      e.len      = len;
      e.words    = '0;
      e.words[0] = W_FETCH;
      e.words[1] = W_DECODE;
      if (len == 3) e.words[2] = last_word;
      e.count    = (exp_retired > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : exp_retired[CNT_W-1:0];
      sb.push_back(e);
    end
  endtask

  task automatic flush_trace();
    exp_t             e;
    logic [5:0][10:0] got;
    got = '0;
    for (int i = 0; i < trace.size() && i < 6; i++) got[i] = trace[i];
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL unexpected_instr: got trace %h, expected no instruction", got);
    end else begin
      e = sb.pop_front();
      check_output(e.name, {4'(trace.size()), got, instr_count}, {4'(e.len), e.words, e.count});
      halt_count = e.count;
    end
  endtask

  // Monitor: an instruction's trace closes at the next FETCH, or at its first HALT cycle.
  always @(negedge clk) begin
    if (rst) begin
      trace.delete();
      halted = 1'b0;
    end else if (halted) begin
      check_output("halt_hold", {ctrl_word(), instr_count}, {W_HALT, halt_count});
    end else if (ir_enable) begin
      if (trace.size() > 0) flush_trace();
      trace.delete();
      trace.push_back(ctrl_word());
    end else begin
      if (trace.size() < 6) trace.push_back(ctrl_word());
      if (halt) begin
        flush_trace();
        trace.delete();
        halted = 1'b1;
      end
    end
  end

  task automatic release_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_output("release_fetch", {ctrl_word(), instr_count}, {W_FETCH, 5'd0});
  endtask

  initial begin
    rst = 1'b1;
    decoded_instruction = I_NOP;
    {zero_op, neg_op, unsigned_overflow, signed_overflow} = 4'b0000;
    repeat (3) @(negedge clk);
    check_output("reset_ctrl", {ctrl_word(), instr_count}, 16'd0);
    release_reset();

    apply_stimulus("add",      I_ADD,    4'b0000, 3, W_ADD,   1, 1);
    apply_stimulus("sub",      I_SUB,    4'b0000, 3, W_SUB,   1, 1);
    apply_stimulus("and",      I_AND,    4'b0000, 3, W_AND,   1, 1);
    apply_stimulus("or",       I_OR,     4'b0000, 3, W_OR,    1, 1);
    apply_stimulus("move",     I_MOVE,   4'b0000, 3, W_MOVE,  1, 1);
    apply_stimulus("load",     I_LOAD,   4'b0000, 3, W_LOAD,  1, 1);
    apply_stimulus("store",    I_STORE,  4'b0000, 3, W_STORE, 1, 1);
    apply_stimulus("nop",      I_NOP,    4'b0000, 2, W_FETCH, 1, 1);
    apply_stimulus("branch",   I_BRANCH, 4'b0000, 3, W_BR,    1, 1);
    apply_stimulus("bzero_t",  I_BZERO,  4'b1100, 3, W_BR,    1, 1);
    apply_stimulus("bzero_n",  I_BZERO,  4'b0111, 2, W_FETCH, 1, 1);
    apply_stimulus("bnzero_t", I_BNZERO, 4'b0000, 3, W_BR,    1, 1);
    apply_stimulus("bnzero_n", I_BNZERO, 4'b1000, 2, W_FETCH, 1, 1);
    apply_stimulus("bneg_t",   I_BNEG,   4'b0100, 3, W_BR,    1, 1);
    apply_stimulus("bneg_n",   I_BNEG,   4'b1011, 2, W_FETCH, 1, 1);
    apply_stimulus("bnneg_t",  I_BNNEG,  4'b0000, 3, W_BR,    1, 1);
    apply_stimulus("bnneg_n",  I_BNNEG,  4'b0100, 2, W_FETCH, 1, 1);
    apply_stimulus("bov_u",    I_BOV,    4'b0010, 3, W_BR,    1, 1);
    apply_stimulus("bov_s",    I_BOV,    4'b0001, 3, W_BR,    1, 1);
    apply_stimulus("bov_n",    I_BOV,    4'b1100, 2, W_FETCH, 1, 1);
    apply_stimulus("bnov_t",   I_BNOV,   4'b1100, 3, W_BR,    1, 1);
    apply_stimulus("bnov_u",   I_BNOV,   4'b0010, 2, W_FETCH, 1, 1);
    apply_stimulus("bnov_s",   I_BNOV,   4'b0001, 2, W_FETCH, 1, 1);
    apply_stimulus("halt",     I_HALT,   4'b0000, 3, W_HALT,  0, 1);

    repeat (102) @(negedge clk);
    #2 rst = 1'b1;
    exp_retired = 0;
    #1 check_output("halt_rst", {ctrl_word(), instr_count}, 16'd0);
    repeat (2) @(negedge clk);
    release_reset();

    apply_stimulus("add_rst", I_ADD, 4'b0000, 3, W_ADD, 1, 0);
    repeat (2) @(negedge clk);
    check_output("alu_before_rst", ctrl_word(), W_ADD);
    #2 rst = 1'b1;
    exp_retired = 0;
    #1 check_output("alu_rst", {ctrl_word(), instr_count}, 16'd0);
    repeat (2) @(negedge clk);
    release_reset();

    for (int k = 1; k <= CNT_MAX + 3; k++)
      apply_stimulus($sformatf("sat_nop_%0d", k), I_NOP, 4'b0000, 2, W_FETCH, 1, 1);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
